loop_add_const_pipe: RTL and testbench

// - Parametrised, pipelined successor to the fixed loop_add_7 kernel: dst[i] = src[i] (+|-) k, i = 0..len-1.
// - Base addresses, length, constant and op are runtime inputs, captured on start; issues one element per cycle (II=1).
// - Sits beside the RAM2 model: drives raddr_0/rdata_0 and waddr_0/wdata_0/wen_0; RAM2 debug ports stay testbench-only.

---
 rtl/loop_kernel_pkg.sv | 17 +
 rtl/loop_add_const_pipe_delay_line.sv | 46 ++++
 rtl/loop_add_const_pipe.sv | 135 +++++++++++++
 tb/tb_loop_add_const_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_kernel_pkg.sv
// Shared types and constants for the loop_* RAM kernels.
// Holds the kernel FSM encoding and the add/subtract op codes.
package loop_kernel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/loop_add_const_pipe_delay_line.sv
// Valid-tagged shift register that carries a payload alongside the RAM read latency.
// DEPTH=0 degenerates to a wire; any_valid reports whether an element is still in flight.
module hls_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         any_valid
);
    localparam int SZ = (DEPTH > 0) ? DEPTH : 1;

    logic [SZ-1:0] valid_q;
    logic [SZ-1:0] valid_d;
    logic [W-1:0]  data_q [SZ];
    logic [W-1:0]  data_d [SZ];

    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int s = 1; s < SZ; s++) begin
            valid_d[s] = valid_q[s-1];
            data_d[s]  = data_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int s = 0; s < SZ; s++) data_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < SZ; s++) data_q[s] <= data_d[s];
        end
    end

    // With no latency the single stage is bypassed and never reports occupancy.
    assign out_valid = (DEPTH == 0) ? in_valid : valid_q[SZ-1];
    assign out_data  = (DEPTH == 0) ? in_data  : data_q[SZ-1];
    assign any_valid = (DEPTH == 0) ? 1'b0     : |valid_q;

endmodule

// File: rtl/loop_add_const_pipe.sv
// Pipelined dst[i] = src[i] +/- k kernel over a single-port-pair RAM, one element per cycle.
// Operands are latched on an accepted start; the destination address rides with the read latency.
module loop_add_const_pipe
    import loop_kernel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 6,
    parameter int RD_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] k,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              valid,
    output logic [ADDR_W-1:0] raddr_0,
    input  logic [DATA_W-1:0] rdata_0,
    output logic [ADDR_W-1:0] waddr_0,
    output logic [DATA_W-1:0] wdata_0,
    output logic              wen_0
);
    state_t            state_q, state_d;
    logic              accept;
    logic              issue;
    logic              pipe_busy;
    logic              lat_valid;
    logic [ADDR_W-1:0] lat_addr;

    logic              op_q, op_d;
    logic [DATA_W-1:0] k_q, k_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] dptr_q, dptr_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign issue  = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // RUN ends on the last issued read; DRAIN waits for the latency stages to empty,
    // so DONE begins right after the final write retires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (len == '0) ? DONE : RUN;
            RUN:        if (cnt_q == LEN_W'(1)) state_d = DRAIN;
            DRAIN:      if (!pipe_busy) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == RUN) || (state_q == DRAIN);
        valid = (state_q == DONE);
    end

    hls_delay_line #(
        .W     (ADDR_W),
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_data   (dptr_q),
        .out_valid (lat_valid),
        .out_data  (lat_addr),
        .any_valid (pipe_busy)
    );

    always_comb begin
        op_d    = op_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        dptr_d  = dptr_q;
        wen_d   = lat_valid;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (accept) begin
            op_d    = op;
            k_d     = k;
            cnt_d   = len;
            raddr_d = src_base;
            dptr_d  = dst_base;
        end else if (issue) begin
            cnt_d   = cnt_q - LEN_W'(1);
            raddr_d = raddr_q + ADDR_W'(1);
            dptr_d  = dptr_q + ADDR_W'(1);
        end
        // Write outputs only move when an element arrives, so they hold between runs.
        if (lat_valid) begin
            waddr_d = lat_addr;
            wdata_d = (op_q == OP_SUB) ? (rdata_0 - k_q) : (rdata_0 + k_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q    <= OP_ADD;
            k_q     <= '0;
            cnt_q   <= '0;
            raddr_q <= '0;
            dptr_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            op_q    <= op_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            dptr_q  <= dptr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign raddr_0 = raddr_q;
    assign waddr_0 = waddr_q;
    assign wdata_0 = wdata_q;
    assign wen_0   = wen_q;

endmodule

// File: tb/tb_loop_add_const_pipe.sv
// Scoreboard bench for loop_add_const_pipe built with a two-cycle read latency RAM.
// Expected writes come from a shadow memory; a negedge monitor pops and checks each write.
module tb_loop_add_const_pipe;
    import loop_kernel_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LEN_W  = 6;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              op;
    logic [DATA_W-1:0] k;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              valid;
    logic [ADDR_W-1:0] raddr_0;
    logic [DATA_W-1:0] rdata_0;
    logic [ADDR_W-1:0] waddr_0;
    logic [DATA_W-1:0] wdata_0;
    logic              wen_0;

    logic [DATA_W-1:0] ram       [DEPTH];
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] rd_pipe   [RD_LAT];
    logic              tb_we;
    logic [ADDR_W-1:0] tb_addr;
    logic [DATA_W-1:0] tb_data;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    loop_add_const_pipe #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .k        (k),
        .src_base (src_base),
        .dst_base (dst_base),
        .len      (len),
        .busy     (busy),
        .valid    (valid),
        .raddr_0  (raddr_0),
        .rdata_0  (rdata_0),
        .waddr_0  (waddr_0),
        .wdata_0  (wdata_0),
        .wen_0    (wen_0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle number: period c is the time after the c-th rising edge.
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // RAM with a registered read pipeline; the bench can also preload words through tb_we.
    initial forever begin
        @(posedge clk);
        if (wen_0 === 1'b1) ram[waddr_0] <= wdata_0;
        if (tb_we === 1'b1) ram[tb_addr] <= tb_data;
        rd_pipe[0] <= ram[raddr_0];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign rdata_0 = rd_pipe[RD_LAT-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT write must match the head of the scoreboard, including its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wen_0 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_write: got write to 0x%0h at cycle %0d, expected none", waddr_0, cyc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("waddr", 64'(waddr_0), 64'(e.addr));
                    checkOutput("wdata", 64'(wdata_0), 64'(e.data));
                    checkOutput("wcycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pokeMem(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
        model_mem[a] = d;
    endtask

    // Issues one run from a negedge, queues its expected writes and checks handshake timing.
    task automatic applyStimulus(input logic op_i, input logic [DATA_W-1:0] k_i,
                                 input logic [ADDR_W-1:0] src_i, input logic [ADDR_W-1:0] dst_i,
                                 input logic [LEN_W-1:0] len_i, input bit poke);
        exp_t              run_q[$];
        exp_t              e;
        logic [ADDR_W-1:0] sa;
        int                c_s;
        int                lat;
        c_s = cyc;
        for (int i = 0; i < int'(len_i); i++) begin
            sa     = src_i + ADDR_W'(i);
            e.addr = dst_i + ADDR_W'(i);
            e.data = (op_i == OP_SUB) ? model_mem[sa] - k_i : model_mem[sa] + k_i;
            e.cyc  = c_s + 2 + i + RD_LAT;
            run_q.push_back(e);
            exp_q.push_back(e);
        end
        lat = (len_i == '0) ? 1 : int'(len_i) + RD_LAT + 2;
        op       = op_i;
        k        = k_i;
        src_base = src_i;
        dst_base = dst_i;
        len      = len_i;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        op       = 1'($urandom);
        k        = $urandom;
        src_base = ADDR_W'($urandom);
        dst_base = ADDR_W'($urandom);
        len      = LEN_W'($urandom);
        checkOutput("busy_after_accept", 64'(busy), 64'(len_i != '0));
        if (len_i != '0) checkOutput("valid_cleared", 64'(valid), 64'(0));
        if (poke && len_i != '0) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (valid !== 1'b1 && cyc < c_s + 300) @(negedge clk);
        checkOutput("done_latency", 64'(cyc - c_s), 64'(lat));
        checkOutput("busy_at_done", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        checkOutput("valid_sticky", 64'(valid), 64'(1));
        checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));
        foreach (run_q[j]) model_mem[run_q[j].addr] = run_q[j].data;
    endtask

    // Six-element run cut by reset right after its second write retires.
    task automatic resetMidRun();
        exp_t              run_q[$];
        exp_t              e;
        logic [DATA_W-1:0] kk;
        int                c_s;
        kk  = $urandom;
        c_s = cyc;
        for (int i = 0; i < 6; i++) begin
            e.addr = ADDR_W'(16 + i);
            e.data = model_mem[i] + kk;
            e.cyc  = c_s + 2 + i + RD_LAT;
            run_q.push_back(e);
            exp_q.push_back(e);
        end
        op       = OP_ADD;
        k        = kk;
        src_base = '0;
        dst_base = ADDR_W'(16);
        len      = LEN_W'(6);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c_s + 3 + RD_LAT) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_wen", 64'(wen_0), 64'(0));
        checkOutput("rst_mid_busy", 64'(busy), 64'(0));
        checkOutput("rst_mid_valid", 64'(valid), 64'(0));
        checkOutput("rst_mid_pending", 64'(exp_q.size()), 64'(4));
        exp_q.delete();
        rst = 1'b1;
        for (int j = 0; j < 2; j++) model_mem[run_q[j].addr] = run_q[j].data;
        @(negedge clk);
    endtask

    initial begin
        logic [ADDR_W-1:0] rs;
        bit                inplace;
        rst      = 1'b0;
        start    = 1'b0;
        op       = OP_ADD;
        k        = '0;
        src_base = '0;
        dst_base = '0;
        len      = '0;
        tb_we    = 1'b0;
        tb_addr  = '0;
        tb_data  = '0;
        @(negedge clk);
        for (int a = 0; a < DEPTH; a++) pokeMem(ADDR_W'(a), $urandom);

        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_valid", 64'(valid), 64'(0));
        checkOutput("reset_wen", 64'(wen_0), 64'(0));
        checkOutput("reset_raddr", 64'(raddr_0), 64'(0));
        checkOutput("reset_waddr", 64'(waddr_0), 64'(0));
        checkOutput("reset_wdata", 64'(wdata_0), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] legacy add case");
        pokeMem(ADDR_W'(10), 32'd10);
        pokeMem(ADDR_W'(11), 32'd5);
        applyStimulus(OP_ADD, 32'd7, ADDR_W'(10), ADDR_W'(0), LEN_W'(2), 1'b0);
        checkOutput("legacy_mem0", 64'(ram[0]), 64'(17));
        checkOutput("legacy_mem1", 64'(ram[1]), 64'(12));

        $display("[TB] address wrap and carry discard");
        pokeMem(ADDR_W'(31), 32'hFFFF_FFFF);
        applyStimulus(OP_ADD, 32'd7, ADDR_W'(30), ADDR_W'(8), LEN_W'(4), 1'b0);
        checkOutput("wrap_mem9", 64'(ram[9]), 64'(6));

        $display("[TB] subtract borrow and zero length");
        pokeMem(ADDR_W'(3), 32'd3);
        applyStimulus(OP_SUB, 32'd5, ADDR_W'(3), ADDR_W'(20), LEN_W'(1), 1'b0);
        checkOutput("sub_mem20", 64'(ram[20]), 64'(32'hFFFF_FFFE));
        applyStimulus(OP_ADD, 32'd1, ADDR_W'(0), ADDR_W'(0), LEN_W'(0), 1'b0);

        $display("[TB] latency run, start while busy, in-place");
        applyStimulus(OP_ADD, $urandom, ADDR_W'(4), ADDR_W'(24), LEN_W'(5), 1'b0);
        applyStimulus(OP_ADD, $urandom, ADDR_W'(12), ADDR_W'(28), LEN_W'(6), 1'b1);
        applyStimulus(OP_SUB, $urandom, ADDR_W'(5), ADDR_W'(5), LEN_W'(8), 1'b0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 12; r++) begin
            rs      = ADDR_W'($urandom);
            inplace = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom), $urandom, rs, inplace ? rs : rs + ADDR_W'(16),
                          LEN_W'($urandom_range(0, 16)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset mid-run then restart");
        resetMidRun();
        applyStimulus(OP_ADD, $urandom, ADDR_W'(2), ADDR_W'(18), LEN_W'(6), 1'b0);

        for (int a = 0; a < DEPTH; a++) checkOutput($sformatf("mem_%0d", a), 64'(ram[a]), 64'(model_mem[a]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
